// File: rtl/collision_pkg.sv
// Shared types for the collision engine: tile codes, result codes, FSM states
// and score constants.
package collision_pkg;

  typedef enum logic [1:0] {
    T_EMPTY = 2'd0,
    T_WALL  = 2'd1,
    T_DOT   = 2'd2,
    T_PILL  = 2'd3
  } tile_t;

  typedef enum logic [2:0] {
    CT_NONE       = 3'd0,
    CT_WALL       = 3'd1,
    CT_DOT        = 3'd2,
    CT_PILL       = 3'd3,
    CT_GHOST_KILL = 3'd4,
    CT_GHOST_EAT  = 3'd5
  } coll_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [19:0] SCORE_DOT   = 20'd10;
  localparam logic [19:0] SCORE_PILL  = 20'd50;
  localparam logic [19:0] SCORE_GHOST = 20'd200;
  localparam logic [19:0] SCORE_MAX   = 20'hFFFFF;

endpackage

// File: rtl/collision_engine_power_timer.sv
// Power-pill countdown: a load adds PILL_TICKS (saturating at all-ones),
// otherwise the count decrements toward zero every cycle.
module power_timer #(
  parameter int              PWR_W      = 32,
  parameter longint unsigned PILL_TICKS = 64'd1500000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  output logic [PWR_W-1:0] ticks_out
);

  localparam int SUM_W = PWR_W + 1;
  localparam logic [PWR_W:0] ADD = SUM_W'(PILL_TICKS);

  logic [PWR_W:0] sum;

  // Extra carry bit detects overflow of the extended count
  assign sum = {1'b0, ticks_out} + ADD;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ticks_out <= '0;
    end else if (load) begin
      ticks_out <= sum[PWR_W] ? '1 : sum[PWR_W-1:0];
    end else if (ticks_out != '0) begin
      ticks_out <= ticks_out - PWR_W'(1);
    end
  end

endmodule

// File: rtl/collision_engine.sv
// Move-request collision checker with row read-modify-write on the map RAM.
// Define COLLISION_SCORE_EN to add the 20-bit saturating score output.
module collision_engine
  import collision_pkg::*;
#(
  parameter int              NUM_GHOSTS = 2,
  parameter int              MAP_COLS   = 40,
  parameter int              MAP_ROWS   = 30,
  parameter int              TILE_W     = 4,
  parameter int              RAM_RD_LAT = 2,
  parameter longint unsigned PILL_TICKS = 64'd1500000000,
  parameter int              PWR_W      = 32,
  localparam int X_W   = $clog2(MAP_COLS),
  localparam int Y_W   = $clog2(MAP_ROWS),
  localparam int GI_W  = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1,
  localparam int ROW_W = MAP_COLS * TILE_W
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_W-1:0]           pac_x,
  input  logic [Y_W-1:0]           pac_y,
  input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               collision_type,
  output logic [GI_W-1:0]          ghost_idx,
  output logic                     power_active,
  output logic [PWR_W-1:0]         power_ticks,
  output logic [15:0]              dots_eaten,
  output logic [Y_W-1:0]           ram_addr,
  output logic [ROW_W-1:0]         ram_wdata,
  output logic                     ram_wren,
  input  logic [ROW_W-1:0]         ram_rdata
`ifdef COLLISION_SCORE_EN
  ,
  output logic [19:0]              score
`endif
);

  localparam int CNT_W = $clog2(RAM_RD_LAT + 1);

  state_t                    state, next;
  logic [CNT_W-1:0]          wait_cnt;
  logic [X_W-1:0]            pac_x_r;
  logic [Y_W-1:0]            pac_y_r;
  logic [NUM_GHOSTS*X_W-1:0] gx_r;
  logic [NUM_GHOSTS*Y_W-1:0] gy_r;
  logic [ROW_W-1:0]          row_r;
  logic [TILE_W-1:0]         tile, tile_r;
  coll_t                     cls, res_type, ent_type;
  logic [GI_W-1:0]           hit_idx, res_ghost, ent_ghost;
  logic                      hit, oor, consume, is_wall, is_dot, is_pill, load;
  int                        tile_sh;

  assign oor = ({1'b0, pac_x} >= (X_W+1)'(MAP_COLS)) || ({1'b0, pac_y} >= (Y_W+1)'(MAP_ROWS));

  // Column 0 sits at the MSBs, so the shift counts from the right-hand end
  assign tile_sh = (MAP_COLS - 1 - int'(pac_x_r)) * TILE_W;
  assign tile    = TILE_W'(ram_rdata >> tile_sh);
  assign is_wall = (tile == TILE_W'(T_WALL));
  assign is_dot  = (tile == TILE_W'(T_DOT));
  assign is_pill = (tile == TILE_W'(T_PILL));

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Descending scan so the lowest matching ghost wins
    for (int g = NUM_GHOSTS - 1; g >= 0; g--) begin
      if (gx_r[g*X_W +: X_W] == pac_x_r && gy_r[g*Y_W +: Y_W] == pac_y_r) begin
        hit     = 1'b1;
        hit_idx = GI_W'(g);
      end
    end
  end

  always_comb begin
    cls = CT_NONE;
    if (hit)          cls = (power_active || is_pill) ? CT_GHOST_EAT : CT_GHOST_KILL;
    else if (is_wall) cls = CT_WALL;
    else if (is_dot)  cls = CT_DOT;
    else if (is_pill) cls = CT_PILL;
    consume = (cls == CT_DOT) || (cls == CT_PILL) ||
              ((cls == CT_GHOST_EAT) && (is_dot || is_pill));
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:  if (start) next = oor ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_cnt == CNT_W'(RAM_RD_LAT - 1)) next = S_CHECK;
      S_CHECK: next = consume ? S_WRITE : S_DONE;
      S_WRITE: next = S_DONE;
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    ent_type  = res_type;
    ent_ghost = res_ghost;
    if (state == S_IDLE) begin
      ent_type  = CT_WALL;
      ent_ghost = '0;
    end else if (state == S_CHECK) begin
      ent_type  = cls;
      ent_ghost = hit_idx;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      res_type       <= CT_NONE;
      res_ghost      <= '0;
      collision_type <= CT_NONE;
      ghost_idx      <= '0;
      dots_eaten     <= '0;
      ram_addr       <= '0;
    end else begin
      state <= next;
      case (state)
        S_IDLE: if (start) begin
          wait_cnt <= '0;
          if (!oor) ram_addr <= pac_y;
        end
        S_WAIT:  wait_cnt <= wait_cnt + CNT_W'(1);
        S_CHECK: begin
          res_type  <= cls;
          res_ghost <= hit_idx;
        end
        S_WRITE: if (dots_eaten != 16'hFFFF) dots_eaten <= dots_eaten + 16'd1;
        default: ;
      endcase
      if (next == S_DONE && state != S_DONE) begin
        collision_type <= ent_type;
        ghost_idx      <= ent_ghost;
      end
    end
  end

  // Request capture and row latch: pure data, no reset needed
  always_ff @(posedge CLOCK_50) begin
    if (state == S_IDLE && start) begin
      pac_x_r <= pac_x;
      pac_y_r <= pac_y;
      gx_r    <= ghost_x;
      gy_r    <= ghost_y;
    end
    if (state == S_CHECK) begin
      row_r  <= ram_rdata;
      tile_r <= tile;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign ram_wren  = (state == S_WRITE);
  assign ram_wdata = row_r & ~(ROW_W'({TILE_W{1'b1}}) << tile_sh);
  assign load      = (state == S_WRITE) && (tile_r == TILE_W'(T_PILL));

  power_timer #(.PWR_W(PWR_W), .PILL_TICKS(PILL_TICKS)) u_power (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load      (load),
    .ticks_out (power_ticks)
  );

  assign power_active = (power_ticks != '0);

`ifdef COLLISION_SCORE_EN
  logic [1:0]  eat_k;
  logic [19:0] pts;
  logic [20:0] score_sum;

  always_comb begin
    pts = '0;
    if (state == S_DONE) begin
      case (collision_type)
        CT_DOT:       pts = SCORE_DOT;
        CT_PILL:      pts = SCORE_PILL;
        CT_GHOST_EAT: pts = SCORE_GHOST << eat_k;
        default:      pts = '0;
      endcase
    end
    score_sum = {1'b0, score} + {1'b0, pts};
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      score <= '0;
      eat_k <= '0;
    end else begin
      score <= score_sum[20] ? SCORE_MAX : score_sum[19:0];
      if (state == S_DONE && collision_type == CT_GHOST_EAT) begin
        if (eat_k != 2'd3) eat_k <= eat_k + 2'd1;
      end else if (!power_active) begin
        eat_k <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/collision_engine.md
Name: collision_engine

Overview:
Parametrised successor to the single-cycle pacman collision checker. Takes one move request (pacman plus NUM_GHOSTS ghost tile positions) through a start/busy/done handshake and performs a row read-modify-write on the external map RAM. Classifies the collision and clears eaten dots and pills. Owns the power-pill countdown, which saturates on extension. Sits between the movement controller and the map RAM; the game FSM consumes its results.

Parameters:
NUM_GHOSTS, 2, number of ghost position inputs (1..8)
MAP_COLS, 40, tiles per row; row word width is MAP_COLS*TILE_W
MAP_ROWS, 30, rows in map RAM
TILE_W, 4, bits per tile code
RAM_RD_LAT, 2, cycles from ram_addr stable to ram_rdata valid
PILL_TICKS, 1500000000, power ticks added per pill (30 s at 50 MHz)
PWR_W, 32, power timer width

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
pac_x  in  clog2(MAP_COLS)  pacman next column
pac_y  in  clog2(MAP_ROWS)  pacman next row
ghost_x  in  NUM_GHOSTS*clog2(MAP_COLS)  packed ghost columns, ghost 0 at LSBs
ghost_y  in  NUM_GHOSTS*clog2(MAP_ROWS)  packed ghost rows
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle result strobe
collision_type  out  3  NONE=0, WALL=1, DOT=2, PILL=3, GHOST_KILL=4, GHOST_EAT=5
ghost_idx  out  clog2(NUM_GHOSTS)  ghost involved; 0 when not a ghost type
power_active  out  1  power_ticks != 0
power_ticks  out  PWR_W  remaining power time
dots_eaten  out  16  saturating count of dots and pills cleared
ram_addr  out  clog2(MAP_ROWS)  row address
ram_wdata  out  MAP_COLS*TILE_W  modified row
ram_wren  out  1  write strobe
ram_rdata  in  MAP_COLS*TILE_W  row read data

Behaviour:
- Reset (async, low): state IDLE; busy, done, ram_wren = 0; collision_type = NONE; ghost_idx, power_ticks, dots_eaten = 0; ram_addr = 0. Reset mid-operation aborts the request; no write is issued.
- Tile codes: 0 empty, 1 wall, 2 dot, 3 pill; all other codes are treated as empty. Column c occupies row bits [(MAP_COLS-c)*TILE_W-1 -: TILE_W], so column 0 sits at the MSBs.
- IDLE: when start=1, capture pac_x, pac_y, ghost_x and ghost_y into registers.
  - If pac_x >= MAP_COLS or pac_y >= MAP_ROWS: go to DONE with type WALL. No RAM access.
  - Otherwise go to WAIT. ram_addr = captured pac_y, held through WRITE.
- WAIT: stays RAM_RD_LAT cycles, then goes to CHECK.
- CHECK: latch ram_rdata and extract the tile. Ghost hit = the lowest index g where ghost(g) equals the pacman position.
  - Ghost hit and (power_active or tile == pill): type GHOST_EAT.
  - Ghost hit, otherwise: type GHOST_KILL. The tile is not modified.
  - No ghost hit, tile wall: type WALL.
  - No ghost hit, tile dot: type DOT.
  - No ghost hit, tile pill: type PILL.
  - No ghost hit, any other tile: type NONE.
  - Any type that consumes a dot or pill (including GHOST_EAT on a dot or pill tile) goes to WRITE. All other types go to DONE.
- WRITE: ram_wren = 1 for exactly one cycle. ram_wdata = latched row with the target tile zeroed. dots_eaten += 1, saturating at 16'hFFFF. If a pill was consumed, load the power timer. Then go to DONE.
- DONE: done = 1 for one cycle; collision_type and ghost_idx update on entry and hold until the next DONE. Then go to IDLE.
- Latency: start edge to done-high is RAM_RD_LAT+2 cycles without a write, RAM_RD_LAT+3 with a write, and 1 cycle for out-of-range coordinates.
- start while busy is ignored; it is neither queued nor an error.
- Power timer:
  - Decrements by 1 each cycle while nonzero.
  - On a load cycle the result is min(ticks+PILL_TICKS, 2^PWR_W-1), with no decrement that cycle.
  - The timer runs independently of the FSM state.

Optional Feature:
COLLISION_SCORE_EN. When defined, adds output score [19:0]. It is updated in WRITE or DONE: dot +10, pill +50, GHOST_EAT +200<<k, where k counts ghosts eaten within the current power period, capped at 3. k clears when power_ticks reaches 0. score saturates and resets to 0. When undefined, the port and all of its logic are absent and behaviour is otherwise identical.

Decomposition:
- Package collision_pkg: tile code enum, collision_type enum, FSM state enum, score constants.
- One sub-module, power_timer: saturating load/extend and decrement; ports CLOCK_50, reset, load, ticks_out.

Test Plan:
- Row 3, col 5 holds a dot (2); start with pac=(5,3), no ghost overlap. Expect DOT at done RAM_RD_LAT+3 cycles after start, one ram_wren with col 5 zeroed, dots_eaten=1.
- Pill at (0,0). Expect PILL, power_ticks=1500000000 the cycle after WRITE, then decreasing by 1 per cycle. A second pill with PWR_W=31 saturates at 2^31-1.
- Ghost 1 and pacman both at (7,2) on a dot, power off. Expect GHOST_KILL, ghost_idx=1, no write, dots_eaten unchanged.
- Ghosts 0 and 1 both at pacman's tile while power is active. Expect GHOST_EAT, ghost_idx=0.
- pac_x=45 with MAP_COLS=40. Expect WALL with done 1 cycle after start and no RAM activity. Start pulses while busy produce no extra done.
- Assert reset low during WAIT. Expect immediate IDLE, busy=0, no ram_wren, all outputs at reset values.
